// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-initialisation sequencer: power-up delay, chip-ID check, then
// streams every register-table ROM entry to the SCCB driver one transaction at a time.
module ov5640_cfg_seq #(
    parameter int unsigned REG_NUM  = 250,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PWR_DLY  = 20000,
    parameter int unsigned GAP      = 4,
    parameter logic [15:0] CHIP_ID  = 16'h5640,
    parameter int unsigned ID_RETRY = 3,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              sccb_done,
    input  logic [7:0]        sccb_rd_data,
    output logic              sccb_exc,
    output logic              sccb_rw,
    output logic [23:0]       sccb_data,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int unsigned CNT_A   = (PWR_DLY > TIMEOUT) ? PWR_DLY : TIMEOUT;
    localparam int unsigned CNT_MAX = (CNT_A > GAP) ? CNT_A : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(ID_RETRY + 1);

    typedef enum logic [3:0] {
        PWR_WAIT, ID_HI, ID_LO, ID_CHK, FETCH, ISSUE, WAIT, GAP_W, DONE, ERR
    } state_t;

    // What the transaction in flight is for, so WAIT knows where its result goes.
    typedef enum logic [1:0] {XFER_ID_HI, XFER_ID_LO, XFER_WR} xfer_t;

    state_t             state, state_nxt, ret_state, ret_nxt;
    xfer_t              xfer, xfer_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [15:0]        id, id_nxt;
    logic [RTY_W-1:0]   retry, retry_nxt, retry_inc;
    logic [ADDR_W-1:0]  idx_nxt;
    logic               exc_nxt, rw_nxt, done_nxt, err_nxt;
    logic [23:0]        data_nxt;

    assign cfg_busy = (state != DONE) && (state != ERR);

    always_comb begin
        // NOTE: every *_nxt takes its held value first, so no path through this block infers a latch.
        state_nxt = state;
        ret_nxt   = ret_state;
        xfer_nxt  = xfer;
        cnt_nxt   = cnt;
        id_nxt    = id;
        retry_nxt = retry;
        idx_nxt   = tbl_addr;
        exc_nxt   = 1'b0;
        rw_nxt    = sccb_rw;
        data_nxt  = sccb_data;
        done_nxt  = cfg_done;
        err_nxt   = cfg_err;
        retry_inc = retry + RTY_W'(1);

        case (state)
            PWR_WAIT: begin
                if (cnt == CNT_W'(PWR_DLY - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ID_HI;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ID_HI: begin
                exc_nxt   = 1'b1;
                rw_nxt    = 1'b1;
                data_nxt  = {16'h300A, 8'h00};
                xfer_nxt  = XFER_ID_HI;
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            ID_LO: begin
                exc_nxt   = 1'b1;
                rw_nxt    = 1'b1;
                data_nxt  = {16'h300B, 8'h00};
                xfer_nxt  = XFER_ID_LO;
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            ID_CHK: begin
                if (id == CHIP_ID) begin
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end else begin
                    retry_nxt = retry_inc;
                    cnt_nxt   = '0;
                    if (retry_inc < RTY_W'(ID_RETRY)) begin
                        state_nxt = PWR_WAIT;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end
            end
            FETCH: state_nxt = ISSUE;
            ISSUE: begin
                exc_nxt   = 1'b1;
                rw_nxt    = 1'b0;
                data_nxt  = tbl_data;
                xfer_nxt  = XFER_WR;
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done coincident with our own exc pulse belongs to nothing we issued.
                if (sccb_done && !sccb_exc) begin
                    cnt_nxt = '0;
                    case (xfer)
                        XFER_ID_HI: begin
                            id_nxt[15:8] = sccb_rd_data;
                            ret_nxt      = ID_LO;
                            state_nxt    = GAP_W;
                        end
                        XFER_ID_LO: begin
                            id_nxt[7:0] = sccb_rd_data;
                            ret_nxt     = ID_CHK;
                            state_nxt   = GAP_W;
                        end
                        default: begin
                            if (tbl_addr == ADDR_W'(REG_NUM - 1)) begin
                                done_nxt  = 1'b1;
                                state_nxt = DONE;
                            end else begin
                                idx_nxt   = tbl_addr + ADDR_W'(1);
                                ret_nxt   = FETCH;
                                state_nxt = GAP_W;
                            end
                        end
                    endcase
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP_W: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ret_state;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE, ERR: begin
                if (cfg_start) begin
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    retry_nxt = '0;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = PWR_WAIT;
                end
            end
            default: state_nxt = PWR_WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            ret_state <= PWR_WAIT;
            xfer      <= XFER_ID_HI;
            cnt       <= '0;
            id        <= '0;
            retry     <= '0;
            tbl_addr  <= '0;
            sccb_exc  <= 1'b0;
            sccb_rw   <= 1'b0;
            sccb_data <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            xfer      <= xfer_nxt;
            cnt       <= cnt_nxt;
            id        <= id_nxt;
            retry     <= retry_nxt;
            tbl_addr  <= idx_nxt;
            sccb_exc  <= exc_nxt;
            sccb_rw   <= rw_nxt;
            sccb_data <= data_nxt;
            cfg_done  <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: SCCB driver model plus ROM model, expected transactions
// queued per scenario and popped as the sequencer issues them.
`timescale 1ns/1ps
module tb_ov5640_cfg_seq;

    localparam int PWR_DLY  = 10;
    localparam int GAP      = 2;
    localparam int REG_NUM  = 4;
    localparam int TIMEOUT  = 64;
    localparam int ID_RETRY = 3;
    localparam int ADDR_W   = 8;
    localparam int RESP     = 20;

    typedef struct packed {
        logic        rw;
        logic [23:0] data;
    } xact_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic              sccb_done;
    logic [7:0]        sccb_rd_data;
    logic              sccb_exc, sccb_rw;
    logic [23:0]       sccb_data;
    logic [ADDR_W-1:0] tbl_addr;
    logic [23:0]       tbl_data;
    logic              cfg_busy, cfg_done, cfg_err;

    logic [23:0] rom [4] = '{24'h300882, 24'h310303, 24'h3017FF, 24'h3018FF};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Driver-model knobs, written only by the stimulus block.
    int id_base = 0, n_bad = 0, wr_base = 0, withhold_wr = -1, inj_req = 0;
    bit early_inj = 1'b0, post_inj = 1'b0;

    // Driver-model state, written only by the driver process.
    logic        obs_rw   [256];
    logic [23:0] obs_data [256];
    int          obs_cyc  [256];
    int obs_n = 0, hi_reads = 0, wr_cnt = 0, inj_ack = 0, left = 0, gap_left = 0;
    int long_exc = 0, stab_err = 0;
    bit pend = 1'b0, in_x = 1'b0, prev_exc = 1'b0, last_rw = 1'b0;
    logic [23:0] last_data = '0;
    logic [7:0]  rd_byte = '0;

    xact_t exp_q [$];
    int rd_ptr = 0, scn_base = 0;

    ov5640_cfg_seq #(
        .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .PWR_DLY(PWR_DLY), .GAP(GAP),
        .CHIP_ID(16'h5640), .ID_RETRY(ID_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .sccb_done(sccb_done),
        .sccb_rd_data(sccb_rd_data), .sccb_exc(sccb_exc), .sccb_rw(sccb_rw),
        .sccb_data(sccb_data), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data valid one clock after the address.
    always @(posedge clk) tbl_data <= (tbl_addr < 4) ? rom[tbl_addr[1:0]] : 24'h0;

    // SCCB driver model: logs each exc, answers RESP cycles later, optional fault injection.
    always @(negedge clk) begin
        sccb_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0; in_x = 1'b0; prev_exc = 1'b0; gap_left = 0; sccb_rd_data = 8'h00;
        end else begin
            if (inj_req != inj_ack) begin
                sccb_done = 1'b1;
                inj_ack   = inj_req;
            end
            if (sccb_exc && prev_exc) long_exc++;
            if (in_x && !sccb_exc && (sccb_rw !== last_rw || sccb_data !== last_data)) stab_err++;
            if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) sccb_done = 1'b1;
            end
            if (sccb_exc) begin
                if (obs_n < 256) begin
                    obs_rw[obs_n] = sccb_rw; obs_data[obs_n] = sccb_data; obs_cyc[obs_n] = cyc;
                    obs_n++;
                end
                last_rw = sccb_rw; last_data = sccb_data; in_x = 1'b1;
                if (early_inj) sccb_done = 1'b1;
                pend = 1'b1;
                left = RESP - 1;
                if (sccb_rw) begin
                    if (sccb_data[23:8] == 16'h300A) begin
                        rd_byte = 8'h56;
                        hi_reads++;
                    end else begin
                        rd_byte = (hi_reads - 1 - id_base < n_bad) ? 8'h41 : 8'h40;
                    end
                end else begin
                    if (wr_cnt - wr_base == withhold_wr) pend = 1'b0;
                    wr_cnt++;
                end
            end else if (pend) begin
                left--;
                if (left == 0) begin
                    sccb_done = 1'b1; sccb_rd_data = rd_byte; pend = 1'b0; in_x = 1'b0;
                    if (post_inj) gap_left = 2;
                end
            end
            prev_exc = sccb_exc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_scn();
        scn_base = obs_n;
        rd_ptr   = obs_n;
        exp_q.delete();
    endtask

    task automatic push_id();
        exp_q.push_back({1'b1, 24'h300A00});
        exp_q.push_back({1'b1, 24'h300B00});
    endtask

    task automatic push_tbl(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, rom[i]});
    endtask

    // Pop one expected transaction per logged exc; extras are caught by the count check.
    task automatic drain(input string tag);
        xact_t e;
        while (rd_ptr < obs_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, " rw"}, obs_rw[rd_ptr], e.rw);
                check({tag, " data"}, obs_data[rd_ptr], e.data);
                if (rd_ptr > scn_base)
                    check({tag, " spacing"}, (obs_cyc[rd_ptr] - obs_cyc[rd_ptr - 1] >= RESP), 1);
            end
            rd_ptr++;
        end
    endtask

    task automatic run(input string tag, input int budget, input int stop_obs,
                       input int start_obs, output int end_cyc);
        bit pulsed = 1'b0;
        end_cyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            cfg_start = 1'b0;
            drain(tag);
            if (cfg_done || cfg_err || (stop_obs >= 0 && obs_n >= stop_obs)) begin
                end_cyc = cyc;
                break;
            end
            if (!pulsed && start_obs >= 0 && obs_n >= start_obs) begin
                cfg_start = 1'b1;
                pulsed    = 1'b1;
            end
        end
        cfg_start = 1'b0;
        check({tag, " end reached"}, (end_cyc >= 0), 1);
    endtask

    task automatic pulse_start(output int t_s);
        @(negedge clk); #1;
        cfg_start = 1'b1;
        t_s = cyc;
        @(negedge clk); #1;
        cfg_start = 1'b0;
        check("start clears done", cfg_done, 0);
        check("start clears err", cfg_err, 0);
        check("start sets busy", cfg_busy, 1);
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err);
        check({tag, " cfg_done"}, cfg_done, exp_done);
        check({tag, " cfg_err"}, cfg_err, exp_err);
        check({tag, " cfg_busy"}, cfg_busy, 0);
    endtask

    task automatic check_trace(input string tag, input int n);
        check({tag, " queue drained"}, exp_q.size(), 0);
        check({tag, " xact count"}, obs_n - scn_base, n);
        check({tag, " exc width"}, long_exc, 0);
        check({tag, " data stable"}, stab_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " exc"}, sccb_exc, 0);
        check({tag, " rw"}, sccb_rw, 0);
        check({tag, " data"}, sccb_data, 0);
        check({tag, " tbl_addr"}, tbl_addr, 0);
        check({tag, " done"}, cfg_done, 0);
        check({tag, " err"}, cfg_err, 0);
        check({tag, " busy"}, cfg_busy, 1);
    endtask

    initial begin
        int t_rel, t_s, t_end;

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");

        // Nominal: two ID reads then the four table writes. Counting starts on the first
        // edge after release, so exc appears PWR_DLY+1 cycles later (ID_HI adds one).
        begin_scn(); push_id(); push_tbl(4);
        @(negedge clk); #1;
        rst_n = 1'b1;
        t_rel = cyc;
        run("nominal", 2000, -1, -1, t_end);
        check_end("nominal", 1, 0);
        check_trace("nominal", 6);
        check("nominal pwr delay", obs_cyc[scn_base] - t_rel, PWR_DLY + 1);
        check("nominal done latency", t_end - obs_cyc[obs_n - 1], RESP);

        // ID mismatch on every attempt: three read pairs, no writes, error.
        begin_scn(); id_base = hi_reads; n_bad = 3;
        push_id(); push_id(); push_id();
        pulse_start(t_s);
        run("id bad", 3000, -1, -1, t_end);
        check_end("id bad", 0, 1);
        check_trace("id bad", 6);
        check("id bad first delay", obs_cyc[scn_base] - t_s, PWR_DLY + 2);
        check("id bad retry delay", (obs_cyc[scn_base + 2] - obs_cyc[scn_base + 1] > RESP + PWR_DLY), 1);

        // Mismatch once, then correct ID: table proceeds.
        begin_scn(); id_base = hi_reads; n_bad = 1;
        push_id(); push_id(); push_tbl(4);
        pulse_start(t_s);
        run("id retry", 3000, -1, -1, t_end);
        check_end("id retry", 1, 0);
        check_trace("id retry", 8);
        n_bad = 0;

        // Done withheld on entry 2: error exactly TIMEOUT cycles after its exc, then silence.
        begin_scn(); wr_base = wr_cnt; withhold_wr = 2;
        push_id(); push_tbl(3);
        pulse_start(t_s);
        run("timeout", 2000, -1, -1, t_end);
        check_end("timeout", 0, 1);
        check_trace("timeout", 5);
        check("timeout latency", t_end - obs_cyc[obs_n - 1], TIMEOUT);
        repeat (40) @(negedge clk);
        #1;
        check("timeout no further exc", obs_n - scn_base, 5);
        check("timeout err held", cfg_err, 1);
        withhold_wr = -1;

        // Spurious dones in PWR_WAIT, in the exc cycle and in GAP_W: trace and timing unchanged.
        begin_scn(); early_inj = 1'b1; post_inj = 1'b1;
        push_id(); push_tbl(4);
        pulse_start(t_s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            inj_req++;
        end
        run("spurious", 2000, -1, -1, t_end);
        check_end("spurious", 1, 0);
        check_trace("spurious", 6);
        check("spurious pwr delay", obs_cyc[scn_base] - t_s, PWR_DLY + 2);
        early_inj = 1'b0; post_inj = 1'b0;

        // cfg_start while a table write is pending: ignored.
        begin_scn(); push_id(); push_tbl(4);
        pulse_start(t_s);
        run("mid start", 2000, -1, scn_base + 4, t_end);
        check_end("mid start", 1, 0);
        check_trace("mid start", 6);

        // Reset while waiting on write 0: outputs drop at once, then a clean full rerun.
        begin_scn(); push_id(); push_tbl(1);
        pulse_start(t_s);
        run("pre reset", 2000, scn_base + 3, -1, t_end);
        check("pre reset queue drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid reset");
        repeat (2) @(negedge clk);
        begin_scn(); push_id(); push_tbl(4);
        #1;
        rst_n = 1'b1;
        t_rel = cyc;
        run("after reset", 2000, -1, -1, t_end);
        check_end("after reset", 1, 0);
        check_trace("after reset", 6);
        check("after reset pwr delay", obs_cyc[scn_base] - t_rel, PWR_DLY + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
Register-initialisation sequencer for the OV5640 camera; sits directly upstream of the SCCB driver and feeds it one 24-bit transaction at a time over the exc/done handshake. It waits a power-up delay, then reads and checks the chip ID at 0x300A/0x300B. It then walks an external synchronous register-table ROM, writing every entry, and reports completion or error. Runs on the SCCB driver's dri_clk, connected as clk.

Parameters:
REG_NUM, 250, number of table entries to write (1..2^ADDR_W)
ADDR_W, 8, table address width
PWR_DLY, 20000, clk cycles waited after reset or restart before the first transaction (>=1)
GAP, 4, idle clk cycles between consecutive transactions (>=1)
CHIP_ID, 16'h5640, expected {reg 0x300A, reg 0x300B}
ID_RETRY, 3, ID-check attempts before error (>=1)
TIMEOUT, 4096, max clk cycles from sccb_exc to sccb_done

Ports:
clk  in  1  clock (dri_clk of the SCCB driver)
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse; restarts the sequence, honoured only in DONE/ERR
sccb_done  in  1  one-cycle pulse, transaction finished
sccb_rd_data  in  8  read byte, valid in the sccb_done cycle of a read
sccb_exc  out  1  one-cycle transaction start pulse
sccb_rw  out  1  1 = read, 0 = write
sccb_data  out  24  [23:8] register address, [7:0] write data (0 for reads)
tbl_addr  out  ADDR_W  ROM address
tbl_data  in  24  ROM word, valid one clk after tbl_addr changes
cfg_busy  out  1  high in every state except DONE/ERR
cfg_done  out  1  high, held, once all REG_NUM writes complete
cfg_err  out  1  high, held, on ID mismatch exhaustion or timeout

Behaviour:
- Reset (async, rst_n=0): state PWR_WAIT, counters 0, sccb_exc=0, sccb_rw=0, sccb_data=0, tbl_addr=0, cfg_done=0, cfg_err=0, cfg_busy=1. A reset mid-transaction abandons it; no completion is owed.
- States: PWR_WAIT, ID_HI, ID_LO, ID_CHK, FETCH, ISSUE, WAIT, GAP_W, DONE, ERR.
- PWR_WAIT: counts PWR_DLY cycles, then -> ID_HI.
- Issuing a transaction: sccb_data and sccb_rw are set in the same cycle as the sccb_exc pulse. Both stay stable until sccb_done. sccb_exc is high for exactly 1 cycle. The timeout counter starts at exc.
- ID_HI: issues read {16'h300A, 8'h00}, rw=1. On done, latches sccb_rd_data into id[15:8] -> GAP_W -> ID_LO.
- ID_LO: same flow for 0x300B into id[7:0] -> ID_CHK.
- ID_CHK (1 cycle):
  - id == CHIP_ID -> FETCH with tbl index 0.
  - Otherwise retry count increments; if retry count < ID_RETRY -> PWR_WAIT (full delay again), else -> ERR.
- FETCH: drives tbl_addr = index, waits 1 cycle -> ISSUE.
- ISSUE: sccb_data <= tbl_data, rw=0, exc pulse -> WAIT.
- WAIT: on sccb_done:
  - If index == REG_NUM-1 -> DONE.
  - Otherwise index++ -> GAP_W -> FETCH.
  - The index never wraps.
- GAP_W: GAP idle cycles, then to the recorded next state.
- Timeout: if sccb_done is absent for TIMEOUT cycles after exc in any wait -> ERR.
- Spurious sccb_done: a done outside a wait state is ignored. A done in the same cycle as exc is not accepted; the earliest valid done is exc+1.
- DONE: cfg_done=1, cfg_busy=0. ERR: cfg_err=1, cfg_busy=0. Both hold until cfg_start.
- cfg_start in DONE/ERR: clears cfg_done, cfg_err, the retry count and the index, then -> PWR_WAIT. cfg_start in any other state has no effect.
- cfg_done and cfg_err are never high simultaneously.

Test Plan:
- Nominal (PWR_DLY=10, GAP=2, REG_NUM=4, ROM entries 0x3008_82, 0x3103_03, 0x3017_FF, 0x3018_FF; driver model answers done 20 cycles after exc, ID bytes 0x56/0x40): expect 2 reads then 4 writes with exact ROM words and rw=0, 1-cycle exc pulses, cfg_done=1 after the 4th done, cfg_err=0.
- ID mismatch: model returns 0x56/0x41 always -> 3 ID attempts, each preceded by 10-cycle delay, then cfg_err=1, no writes issued. Second case: mismatch on attempt 1, correct on attempt 2 -> table proceeds normally.
- Timeout (TIMEOUT=64): model withholds done on table entry 2 -> cfg_err=1 exactly 64 cycles after that exc, no further exc.
- Spurious/early done: done pulses injected in PWR_WAIT, GAP_W and in the exc cycle -> ignored; sequence and index unchanged.
- Restart and reset: cfg_start in DONE -> full rerun, identical transaction trace. cfg_start pulsed mid-table -> no effect. rst_n low mid-WAIT -> all outputs return to reset values immediately and the sequence reruns from PWR_WAIT.
